// File: rtl/timer_pkg.sv
// Shared constants for the programmable interval timer: FSM state encodings,
// mode encodings and a counter-width helper.
package timer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Bits needed to hold values 0..value, never less than one bit.
  function automatic int bits_for(input int unsigned value);
    if (value < 2)
      return 1;
    return $clog2(value + 1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every PRESCALE enabled cycles.
// With PRESCALE=1 the counter is pinned at zero, so tick simply follows en.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = bits_for(PRESCALE - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/prog_interval_timer.sv
// Programmable interval timer: run-time period with a shadow register,
// one-shot or periodic operation, start/stop control and a tick prescaler.
module prog_interval_timer
  import timer_pkg::*;
#(
  parameter int WIDTH          = 21,
  parameter int DEFAULT_PERIOD = 2000000,
  parameter int PRESCALE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             period_load,
  input  logic [WIDTH-1:0] period_in,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_PERIOD);

  logic [0:0]       state;
  logic             mode_q;
  logic [WIDTH-1:0] shadow_period;
  logic             tick;
  logic             presc_clear;

  // Restarting or aborting realigns the prescaler so the first tick of a run
  // always lands PRESCALE cycles after the start.
  assign presc_clear = start | stop | (state != ST_RUN);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(presc_clear),
    .en   (state == ST_RUN),
    .tick (tick)
  );

  // stop outranks start; start outranks any tick, so a restart never emits done.
  // A one-shot run stays in RUN for the done cycle and drops out on the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      count         <= '0;
      done          <= 1'b0;
      period        <= RESET_PERIOD;
      shadow_period <= RESET_PERIOD;
      mode_q        <= MODE_ONESHOT;
    end else begin
      done <= 1'b0;

      if (period_load)
        shadow_period <= period_in;

      if (stop) begin
        state <= ST_IDLE;
        count <= '0;
      end else if (start) begin
        state  <= ST_RUN;
        count  <= '0;
        period <= period_load ? period_in : shadow_period;
        mode_q <= mode;
      end else if (state == ST_RUN) begin
        if (done && (mode_q == MODE_ONESHOT)) begin
          state <= ST_IDLE;
          count <= '0;
        end else if (tick) begin
          if (count == period) begin
            done  <= 1'b1;
            count <= '0;
            if (mode_q == MODE_PERIODIC)
              period <= shadow_period;
          end else begin
            count <= count + 1'b1;
          end
        end
      end
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_prog_interval_timer.sv
// Directed bench: one timer with PRESCALE=1/P=4 and one with PRESCALE=3/P=1.
// Cycle c=0 is the cycle right after the edge that accepts start.
module tb_prog_interval_timer;

  logic       clk;
  logic       reset;

  logic       a_start, a_stop, a_mode, a_load;
  logic [7:0] a_pin;
  logic       a_done, a_busy;
  logic [7:0] a_count, a_period;

  logic       b_start, b_stop, b_mode, b_load;
  logic [7:0] b_pin;
  logic       b_done, b_busy;
  logic [7:0] b_count, b_period;

  int n_compared;
  int n_mismatched;

  prog_interval_timer #(
    .WIDTH(8), .DEFAULT_PERIOD(4), .PRESCALE(1)
  ) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .mode(a_mode),
    .period_load(a_load), .period_in(a_pin), .done(a_done), .busy(a_busy),
    .count(a_count), .period(a_period)
  );

  prog_interval_timer #(
    .WIDTH(8), .DEFAULT_PERIOD(1), .PRESCALE(3)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .mode(b_mode),
    .period_load(b_load), .period_in(b_pin), .done(b_done), .busy(b_busy),
    .count(b_count), .period(b_period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tickClk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset = 1'b1;
    a_start = 0; a_stop = 0; a_mode = 0; a_load = 0; a_pin = '0;
    b_start = 0; b_stop = 0; b_mode = 0; b_load = 0; b_pin = '0;
    tickClk();
    tickClk();
    checkOutput("rst count", 32'(a_count), 0);
    checkOutput("rst busy", 32'(a_busy), 0);
    checkOutput("rst done", 32'(a_done), 0);
    checkOutput("rst period", 32'(a_period), 4);
    checkOutput("rst b period", 32'(b_period), 1);
    reset = 1'b0;
    tickClk();

    // periodic P=4: done every 5 cycles
    a_mode = 1; a_start = 1; tickClk(); a_start = 0;
    for (int c = 0; c <= 15; c++) begin
      checkOutput($sformatf("t1 done c%0d", c), 32'(a_done), 32'(c > 0 && c % 5 == 0));
      checkOutput($sformatf("t1 count c%0d", c), 32'(a_count), c % 5);
      checkOutput($sformatf("t1 busy c%0d", c), 32'(a_busy), 1);
      tickClk();
    end
    a_stop = 1; tickClk(); a_stop = 0;
    checkOutput("t1 stop busy", 32'(a_busy), 0);
    checkOutput("t1 stop count", 32'(a_count), 0);

    // shadow load mid-run: first interval stays at P=4, then every 3 cycles
    a_mode = 1; a_start = 1; tickClk(); a_start = 0;
    for (int c = 0; c <= 14; c++) begin
      checkOutput($sformatf("t2 done c%0d", c), 32'(a_done),
                  32'(c == 5 || c == 8 || c == 11 || c == 14));
      checkOutput($sformatf("t2 count c%0d", c), 32'(a_count), (c < 5) ? c : (c - 5) % 3);
      checkOutput($sformatf("t2 period c%0d", c), 32'(a_period), (c < 5) ? 4 : 2);
      if (c == 2) begin
        a_load = 1; a_pin = 8'd2;
      end
      tickClk();
      a_load = 0;
    end
    a_stop = 1; tickClk(); a_stop = 0;

    // one-shot with same-cycle load and start (bypass), P=3
    a_mode = 0; a_load = 1; a_pin = 8'd3; a_start = 1; tickClk();
    a_load = 0; a_start = 0;
    checkOutput("t3 period", 32'(a_period), 3);
    for (int c = 0; c <= 6; c++) begin
      checkOutput($sformatf("t3 done c%0d", c), 32'(a_done), 32'(c == 4));
      checkOutput($sformatf("t3 busy c%0d", c), 32'(a_busy), 32'(c <= 4));
      checkOutput($sformatf("t3 count c%0d", c), 32'(a_count), (c < 4) ? c : 0);
      tickClk();
    end

    // restart at count=2 of P=4, then stop+start together
    a_mode = 1; a_load = 1; a_pin = 8'd4; a_start = 1; tickClk();
    a_load = 0; a_start = 0;
    tickClk(); tickClk();
    checkOutput("t4 pre count", 32'(a_count), 2);
    a_start = 1; tickClk(); a_start = 0;
    for (int c = 0; c <= 5; c++) begin
      checkOutput($sformatf("t4 done c%0d", c), 32'(a_done), 32'(c == 5));
      checkOutput($sformatf("t4 count c%0d", c), 32'(a_count), c % 5);
      tickClk();
    end
    a_stop = 1; a_start = 1; tickClk(); a_stop = 0; a_start = 0;
    checkOutput("t4 ss busy", 32'(a_busy), 0);
    checkOutput("t4 ss count", 32'(a_count), 0);
    checkOutput("t4 ss done", 32'(a_done), 0);
    tickClk();
    checkOutput("t4 idle busy", 32'(a_busy), 0);

    // stop on the terminal tick suppresses done
    a_mode = 1; a_load = 1; a_pin = 8'd2; a_start = 1; tickClk();
    a_load = 0; a_start = 0;
    tickClk(); tickClk();
    checkOutput("tstop pre count", 32'(a_count), 2);
    a_stop = 1; tickClk(); a_stop = 0;
    checkOutput("tstop done", 32'(a_done), 0);
    checkOutput("tstop busy", 32'(a_busy), 0);
    checkOutput("tstop count", 32'(a_count), 0);

    // PRESCALE=3, P=1: done every 6 cycles
    b_mode = 1; b_start = 1; tickClk(); b_start = 0;
    for (int c = 0; c <= 12; c++) begin
      checkOutput($sformatf("t5 done c%0d", c), 32'(b_done), 32'(c > 0 && c % 6 == 0));
      checkOutput($sformatf("t5 count c%0d", c), 32'(b_count), (c / 3) % 2);
      checkOutput($sformatf("t5 busy c%0d", c), 32'(b_busy), 1);
      tickClk();
    end
    // period 0 loaded with a restart: done every 3 cycles
    b_load = 1; b_pin = 8'd0; b_start = 1; tickClk();
    b_load = 0; b_start = 0;
    checkOutput("t5 p0 period", 32'(b_period), 0);
    for (int c = 0; c <= 9; c++) begin
      checkOutput($sformatf("t5 p0 done c%0d", c), 32'(b_done), 32'(c > 0 && c % 3 == 0));
      checkOutput($sformatf("t5 p0 count c%0d", c), 32'(b_count), 0);
      tickClk();
    end
    b_stop = 1; tickClk(); b_stop = 0;
    checkOutput("t5 stop busy", 32'(b_busy), 0);

    // reset mid-run restores reset values
    a_mode = 1; a_load = 1; a_pin = 8'd6; a_start = 1; tickClk();
    a_load = 0; a_start = 0;
    tickClk(); tickClk(); tickClk();
    checkOutput("t6 pre count", 32'(a_count), 3);
    checkOutput("t6 pre period", 32'(a_period), 6);
    reset = 1; tickClk();
    checkOutput("t6 count", 32'(a_count), 0);
    checkOutput("t6 busy", 32'(a_busy), 0);
    checkOutput("t6 done", 32'(a_done), 0);
    checkOutput("t6 period", 32'(a_period), 4);
    reset = 0; tickClk();
    checkOutput("t6 post busy", 32'(a_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
